// File: rtl/hub75_bcm_controller.sv
// HUB75 dual-scan panel driver using binary-coded modulation from a 1-cycle-latency pixel RAM.
// Adds global brightness, double-buffered frame select, run enable and a frame-done strobe.
module hub75_bcm_controller #(
  parameter int unsigned MATRIX_COLS = 64,
  parameter int unsigned MATRIX_ROWS = 32,
  parameter int unsigned PWM_BITS    = 8,
  parameter int unsigned BRIGHT_W    = 8,
  localparam int unsigned SR = MATRIX_ROWS / 2,
  localparam int unsigned AW = $clog2(MATRIX_COLS * MATRIX_ROWS) + 1,
  localparam int unsigned RW = (SR > 1) ? $clog2(SR) : 1
) (
  input  logic                  i_clk,
  input  logic                  rst,
  input  logic                  i_enable,
  input  logic                  i_buf_sel,
  input  logic [BRIGHT_W-1:0]   i_brightness,
  input  logic [3*PWM_BITS-1:0] i_pixel_data,
  output logic [AW-1:0]         o_pixel_addr,
  output logic                  o_clk,
  output logic                  o_oe,
  output logic                  o_latch,
  output logic [RW-1:0]         o_row_sel,
  output logic [2:0]            o_color1,
  output logic [2:0]            o_color2,
  output logic                  o_frame_done
);

  localparam int unsigned PW = AW - 1;
  localparam int unsigned CW = $clog2(MATRIX_COLS);
  localparam int unsigned BW = (PWM_BITS > 1) ? $clog2(PWM_BITS) : 1;
  localparam int unsigned DW = BRIGHT_W + PWM_BITS;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH_U, S_FETCH_L, S_SETUP, S_CLK_HI, S_LATCH, S_DISPLAY
  } state_t;

  state_t        state_q, state_d;
  logic [RW-1:0] row_q, row_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CW-1:0] col_q, col_d;
  logic          buf_q, buf_d;
  logic [DW-1:0] cnt_q, cnt_d;

  logic [AW-1:0] addr_d;
  logic          clk_d, oe_d, latch_d, frame_done_d;
  logic [RW-1:0] row_sel_d;
  logic [2:0]    color1_d, color2_d;

  logic [PWM_BITS-1:0] r_ch, g_ch, b_ch;
  logic [2:0]          plane_bits;
  logic [PW-1:0]       pix_u, pix_l;

  // Current bitplane slice of the word on the RAM read bus
  assign r_ch       = i_pixel_data[3*PWM_BITS-1:2*PWM_BITS];
  assign g_ch       = i_pixel_data[2*PWM_BITS-1:PWM_BITS];
  assign b_ch       = i_pixel_data[PWM_BITS-1:0];
  assign plane_bits = {r_ch[bit_q], g_ch[bit_q], b_ch[bit_q]};

  // Next-state, counters and registered-output values
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    bit_d        = bit_q;
    col_d        = col_q;
    buf_d        = buf_q;
    cnt_d        = cnt_q;
    addr_d       = o_pixel_addr;
    row_sel_d    = o_row_sel;
    color1_d     = o_color1;
    color2_d     = o_color2;
    oe_d         = 1'b1;
    frame_done_d = 1'b0;
    pix_u        = '0;
    pix_l        = '0;

    case (state_q)
      S_IDLE: begin
        if (i_enable) begin
          buf_d   = i_buf_sel;
          state_d = S_FETCH_U;
        end
      end
      S_FETCH_U: state_d = S_FETCH_L;
      S_FETCH_L: begin
        color1_d = plane_bits;
        state_d  = S_SETUP;
      end
      S_SETUP: begin
        color2_d = plane_bits;
        state_d  = S_CLK_HI;
      end
      S_CLK_HI: begin
        if (col_q == CW'(MATRIX_COLS - 1)) begin
          col_d     = '0;
          row_sel_d = row_q;
          state_d   = S_LATCH;
        end else begin
          col_d   = col_q + CW'(1);
          state_d = S_FETCH_U;
        end
      end
      S_LATCH: begin
        // On-time is fixed here; later brightness changes wait for the next plane
        cnt_d   = DW'(i_brightness) << bit_q;
        oe_d    = (i_brightness == '0);
        state_d = S_DISPLAY;
      end
      S_DISPLAY: begin
        if (cnt_q > DW'(1)) begin
          cnt_d = cnt_q - DW'(1);
          oe_d  = 1'b0;
        end else begin
          cnt_d = '0;
          if (bit_q != BW'(PWM_BITS - 1)) begin
            bit_d   = bit_q + BW'(1);
            state_d = S_FETCH_U;
          end else if (row_q != RW'(SR - 1)) begin
            bit_d   = '0;
            row_d   = row_q + RW'(1);
            state_d = S_FETCH_U;
          end else begin
            bit_d        = '0;
            row_d        = '0;
            frame_done_d = 1'b1;
            if (i_enable) begin
              buf_d   = i_buf_sel;
              state_d = S_FETCH_U;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    pix_u = PW'(row_d) * PW'(MATRIX_COLS) + PW'(col_d);
    pix_l = (PW'(row_d) + PW'(SR)) * PW'(MATRIX_COLS) + PW'(col_d);
    if (state_d == S_FETCH_U)
      addr_d = {buf_d, pix_u};
    else if (state_d == S_FETCH_L)
      addr_d = {buf_d, pix_l};

    clk_d   = (state_d == S_CLK_HI);
    latch_d = (state_d == S_LATCH);
  end

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= '0;
      bit_q        <= '0;
      col_q        <= '0;
      buf_q        <= 1'b0;
      cnt_q        <= '0;
      o_pixel_addr <= '0;
      o_clk        <= 1'b0;
      o_oe         <= 1'b1;
      o_latch      <= 1'b0;
      o_row_sel    <= '0;
      o_color1     <= '0;
      o_color2     <= '0;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      bit_q        <= bit_d;
      col_q        <= col_d;
      buf_q        <= buf_d;
      cnt_q        <= cnt_d;
      o_pixel_addr <= addr_d;
      o_clk        <= clk_d;
      o_oe         <= oe_d;
      o_latch      <= latch_d;
      o_row_sel    <= row_sel_d;
      o_color1     <= color1_d;
      o_color2     <= color2_d;
      o_frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_hub75_bcm_controller.sv
// Bench for hub75_bcm_controller on a 4x4 panel, 2-bit colour: scoreboarded shift data plus
// per-feature checks of timing, brightness, buffer select, enable and reset behaviour.
module tb_hub75_bcm_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       bsel = 1'b0;
  logic [7:0] bright = 8'd1;
  logic [5:0] pix = '0;
  logic [4:0] o_pixel_addr;
  logic       o_clk, o_oe, o_latch, o_frame_done;
  logic [0:0] o_row_sel;
  logic [2:0] o_color1, o_color2;

  hub75_bcm_controller #(
    .MATRIX_COLS(4), .MATRIX_ROWS(4), .PWM_BITS(2), .BRIGHT_W(8)
  ) dut (
    .i_clk(clk), .rst(rst), .i_enable(en), .i_buf_sel(bsel), .i_brightness(bright),
    .i_pixel_data(pix), .o_pixel_addr(o_pixel_addr), .o_clk(o_clk), .o_oe(o_oe),
    .o_latch(o_latch), .o_row_sel(o_row_sel), .o_color1(o_color1), .o_color2(o_color2),
    .o_frame_done(o_frame_done)
  );

  always #5 clk = ~clk;

  logic [5:0] ram [32];
  always @(posedge clk) pix <= ram[o_pixel_addr];

  typedef struct packed {
    logic [4:0] addr;
    logic [2:0] c1;
    logic [2:0] c2;
  } sb_t;

  int checks = 0;
  int failures = 0;
  sb_t sb_q[$];
  int fd_q[$];
  int rs_q[$];
  int oe_q[$];
  logic [2:0] c1_q[$];
  int cyc = 0;
  int run = 0;
  bit obs_en = 1'b0;
  bit sb_en = 1'b0;

  // Observation at the falling edge: frame-done times, latched rows, on-time runs, shift data
  always @(negedge clk) begin
    if (obs_en) begin
      sb_t e;
      cyc++;
      if (o_frame_done) fd_q.push_back(cyc);
      if (o_latch) rs_q.push_back(int'(o_row_sel));
      if (!o_oe) run++;
      else if (run != 0) begin
        oe_q.push_back(run);
        run = 0;
      end
      if (o_clk) begin
        c1_q.push_back(o_color1);
        if (sb_en) begin
          checks++;
          if (sb_q.size() == 0) begin
            failures++;
            $display("FAIL sb_underflow got=%h exp=<none>", {o_pixel_addr, o_color1, o_color2});
          end else begin
            e = sb_q.pop_front();
            if ({o_pixel_addr, o_color1, o_color2} !== e) begin
              failures++;
              $display("FAIL sb_entry got=%h exp=%h", {o_pixel_addr, o_color1, o_color2}, e);
            end
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    fd_q.delete(); rs_q.delete(); oe_q.delete(); c1_q.delete();
    cyc = 0; run = 0;
  endtask

  task automatic wait_fd(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      tick(1);
      if (o_frame_done) ok = 1'b1;
    end
  endtask

  function automatic logic [2:0] ext(input logic [5:0] w, input int b);
    int rv, gv, bv;
    rv = int'(w) / 16;
    gv = (int'(w) / 4) % 4;
    bv = int'(w) % 4;
    return {1'((rv >> b) & 1), 1'((gv >> b) & 1), 1'((bv >> b) & 1)};
  endfunction

  task automatic push_frame(input int bv);
    sb_t e;
    int ua, la;
    for (int r = 0; r < 2; r++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 4; c++) begin
          ua = bv * 16 + r * 4 + c;
          la = bv * 16 + (r + 2) * 4 + c;
          e.addr = 5'(la);
          e.c1 = ext(ram[ua], b);
          e.c2 = ext(ram[la], b);
          sb_q.push_back(e);
        end
  endtask

  task automatic test_reset();
    logic [15:0] exp_v, got_v;
    exp_v = {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
    tick(3);
    got_v = {o_pixel_addr, o_clk, o_oe, o_latch, o_row_sel, o_color1, o_color2, o_frame_done};
    checks++;
    if (got_v !== exp_v) begin
      failures++;
      $display("FAIL reset_values got=%h exp=%h", got_v, exp_v);
    end
    rst = 1'b0;
    tick(5);
    checks++;
    if ({o_oe, o_clk, o_frame_done} !== 3'b100) begin
      failures++;
      $display("FAIL idle_outputs got=%b exp=100", {o_oe, o_clk, o_frame_done});
    end
  endtask

  task automatic test_scan();
    bit ok;
    int exp_oe;
    for (int i = 0; i < 32; i++) ram[i] = 6'($urandom);
    ram[0] = 6'b10_01_11;
    ram[8] = 6'd0;
    bright = 8'd1; bsel = 1'b0;
    clear_obs(); sb_q.delete();
    push_frame(0); push_frame(0);
    sb_en = 1'b1; obs_en = 1'b1;
    en = 1'b1;
    wait_fd(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL scan_fd1 got=timeout exp=pulse"); end
    en = 1'b0;
    wait_fd(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL scan_fd2 got=timeout exp=pulse"); end
    tick(2);
    checks++;
    if (fd_q.size() != 2 || fd_q[0] != 76 || fd_q[1] - fd_q[0] != 74) begin
      failures++;
      $display("FAIL scan_frame_timing got=n%0d first=%0d exp=n2 first=76 period=74",
               fd_q.size(), fd_q.size() > 0 ? fd_q[0] : -1);
    end
    checks++;
    if (rs_q.size() != 8) begin
      failures++;
      $display("FAIL scan_latch_count got=%0d exp=8", rs_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (rs_q[i] != (i / 2) % 2) begin
          failures++;
          $display("FAIL scan_row_sel[%0d] got=%0d exp=%0d", i, rs_q[i], (i / 2) % 2);
        end
      end
    end
    checks++;
    if (oe_q.size() != 8) begin
      failures++;
      $display("FAIL scan_oe_count got=%0d exp=8", oe_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        exp_oe = (i % 2 == 0) ? 1 : 2;
        checks++;
        if (oe_q[i] != exp_oe) begin
          failures++;
          $display("FAIL scan_on_time[%0d] got=%0d exp=%0d", i, oe_q[i], exp_oe);
        end
      end
    end
    checks++;
    if (c1_q.size() < 8 || c1_q[0] !== 3'b011 || c1_q[4] !== 3'b101) begin
      failures++;
      $display("FAIL colour_extract got=%b/%b exp=011/101",
               c1_q.size() > 0 ? c1_q[0] : 3'bx, c1_q.size() > 4 ? c1_q[4] : 3'bx);
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scan_sb_left got=%0d exp=0", sb_q.size());
    end
  endtask

  task automatic test_brightness();
    bit ok, seen;
    int exp_r [4] = '{3, 2, 1, 2};
    bright = 8'd3;
    clear_obs(); push_frame(0);
    en = 1'b1; tick(1); en = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick(1);
      if (!o_oe) seen = 1'b1;
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL bright_oe_low got=timeout exp=low"); end
    bright = 8'd1;
    wait_fd(300, ok);
    tick(1);
    checks++;
    if (!ok || fd_q.size() != 1 || fd_q[0] != 78) begin
      failures++;
      $display("FAIL bright_frame_len got=%0d exp=78", fd_q.size() > 0 ? fd_q[0] : -1);
    end
    checks++;
    if (oe_q.size() != 4) begin
      failures++;
      $display("FAIL bright_oe_count got=%0d exp=4", oe_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (oe_q[i] != exp_r[i]) begin
          failures++;
          $display("FAIL bright_on_time[%0d] got=%0d exp=%0d", i, oe_q[i], exp_r[i]);
        end
      end
    end
    bright = 8'd0;
    clear_obs(); push_frame(0);
    en = 1'b1; tick(1); en = 1'b0;
    wait_fd(300, ok);
    tick(1);
    checks++;
    if (!ok || oe_q.size() != 0 || fd_q.size() != 1 || fd_q[0] != 74) begin
      failures++;
      $display("FAIL bright_zero got=oe_runs%0d fd=%0d exp=oe_runs0 fd=74",
               oe_q.size(), fd_q.size() > 0 ? fd_q[0] : -1);
    end
  endtask

  task automatic test_buffer();
    bit ok;
    for (int i = 16; i < 32; i++) ram[i] = 6'($urandom);
    bright = 8'd1; bsel = 1'b0;
    clear_obs(); push_frame(0); push_frame(1);
    en = 1'b1;
    tick(20);
    bsel = 1'b1;
    wait_fd(300, ok);
    checks++;
    if (!ok || o_pixel_addr !== 5'd16) begin
      failures++;
      $display("FAIL buf_flip_at_frame got=%0d exp=16", o_pixel_addr);
    end
    en = 1'b0;
    wait_fd(300, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL buf_fd2 got=timeout exp=pulse"); end
    tick(30);
    checks++;
    if (fd_q.size() != 2 || sb_q.size() != 0) begin
      failures++;
      $display("FAIL enable_stop got=fd%0d sb%0d exp=fd2 sb0", fd_q.size(), sb_q.size());
    end
    checks++;
    if ({o_oe, o_clk, o_latch} !== 3'b100) begin
      failures++;
      $display("FAIL idle_after_stop got=%b exp=100", {o_oe, o_clk, o_latch});
    end
  endtask

  task automatic test_reenable();
    bit ok;
    checks++;
    if (o_pixel_addr !== 5'd31) begin
      failures++;
      $display("FAIL reen_addr_before got=%0d exp=31", o_pixel_addr);
    end
    clear_obs(); push_frame(1);
    en = 1'b1;
    tick(1);
    checks++;
    if ({o_pixel_addr, o_oe, o_clk} !== {5'd16, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL reen_first_fetch got=%h exp=%h", {o_pixel_addr, o_oe, o_clk},
               {5'd16, 1'b1, 1'b0});
    end
    en = 1'b0;
    wait_fd(300, ok);
    tick(1);
    checks++;
    if (!ok || sb_q.size() != 0) begin
      failures++;
      $display("FAIL reen_frame got=sb%0d exp=sb0", sb_q.size());
    end
  endtask

  task automatic test_reset_mid();
    bit ok, seen;
    logic [15:0] exp_v, got_v;
    exp_v = {5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 1'b0};
    bright = 8'd2; bsel = 1'b1;
    sb_en = 1'b0; sb_q.delete();
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick(1);
      if (o_clk) seen = 1'b1;
    end
    rst = 1'b1;
    tick(1);
    got_v = {o_pixel_addr, o_clk, o_oe, o_latch, o_row_sel, o_color1, o_color2, o_frame_done};
    checks++;
    if (!seen || got_v !== exp_v) begin
      failures++;
      $display("FAIL reset_mid_shift got=%h exp=%h", got_v, exp_v);
    end
    bsel = 1'b0;
    clear_obs(); push_frame(0); sb_en = 1'b1;
    rst = 1'b0;
    tick(1);
    en = 1'b0;
    wait_fd(300, ok);
    tick(1);
    checks++;
    if (!ok || sb_q.size() != 0 || rs_q.size() != 4 || rs_q[0] != 0) begin
      failures++;
      $display("FAIL reset_restart got=sb%0d latches%0d exp=sb0 latches4", sb_q.size(), rs_q.size());
    end
    sb_en = 1'b0;
    en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      tick(1);
      if (!o_oe) seen = 1'b1;
    end
    rst = 1'b1;
    tick(1);
    got_v = {o_pixel_addr, o_clk, o_oe, o_latch, o_row_sel, o_color1, o_color2, o_frame_done};
    checks++;
    if (!seen || got_v !== exp_v) begin
      failures++;
      $display("FAIL reset_mid_display got=%h exp=%h", got_v, exp_v);
    end
    en = 1'b0;
    rst = 1'b0;
    tick(4);
    checks++;
    if ({o_oe, o_clk, o_frame_done} !== 3'b100) begin
      failures++;
      $display("FAIL reset_then_idle got=%b exp=100", {o_oe, o_clk, o_frame_done});
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) ram[i] = '0;
    test_reset();
    test_scan();
    test_brightness();
    test_buffer();
    test_reenable();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
